// File: rtl/regfile_writer.sv
// Regfile write arbiter: registered pipeline writeback wins; long-latency writes wait in a 2-entry FIFO.
// wb latency 1 cycle, lu latency >= 2 cycles; lu_ready low when FIFO full, stall_req after STARVE_LIMIT blocked cycles.
module regfile_writer #(
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_valid,
  input  logic [4:0]            wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  lu_valid,
  output logic                  lu_ready,
  input  logic [4:0]            lu_addr,
  input  logic [DATA_WIDTH-1:0] lu_data,
  output logic                  rf_we,
  output logic [4:0]            rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  input  logic [4:0]            raddrA,
  input  logic [4:0]            raddrB,
  output logic                  fwdA_hit,
  output logic                  fwdB_hit,
  output logic [DATA_WIDTH-1:0] fwdA_data,
  output logic [DATA_WIDTH-1:0] fwdB_data,
  output logic                  pendA,
  output logic                  pendB,
  output logic                  stall_req
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic                  live;
    logic [4:0]            addr;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t                fifo_q [2];
  entry_t                fifo_d [2];
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;
  logic [CW-1:0]         starve_q, starve_d;
  logic                  stall_q, stall_d;
  logic                  rf_we_q, rf_we_d;
  logic [4:0]            rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;

  logic   enq;
  logic   deq;
  logic   wr_ptr;
  entry_t head;

  assign lu_ready = rst_n && (count_q != 2'd2);
  assign enq      = lu_valid && lu_ready;
  assign deq      = !wb_valid && (count_q != 2'd0);
  assign wr_ptr   = rd_ptr_q ^ count_q[0];
  assign head     = fifo_q[rd_ptr_q];

  // Live is cleared on dequeue so that live alone marks a valid, still-pending write.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      fifo_d[i] = fifo_q[i];
      if (wb_valid && fifo_q[i].addr == wb_addr) begin
        fifo_d[i].live = 1'b0;
      end
    end
    if (deq) begin
      fifo_d[rd_ptr_q].live = 1'b0;
    end
    if (enq) begin
      fifo_d[wr_ptr].live = (lu_addr != 5'd0) && !(wb_valid && wb_addr == lu_addr);
      fifo_d[wr_ptr].addr = lu_addr;
      fifo_d[wr_ptr].data = lu_data;
    end
  end

  always_comb begin
    rd_ptr_d = deq ? ~rd_ptr_q : rd_ptr_q;
    count_d  = count_q;
    unique case ({enq, deq})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (wb_valid) begin
      rf_we_d    = (wb_addr != 5'd0);
      rf_waddr_d = wb_addr;
      rf_wdata_d = wb_data;
    end else if (count_q != 2'd0) begin
      rf_we_d    = head.live;
      rf_waddr_d = head.addr;
      rf_wdata_d = head.data;
    end
  end

  // Counter saturates at the limit; only a dequeue releases the stall.
  always_comb begin
    starve_d = '0;
    stall_d  = stall_q;
    if (deq) begin
      starve_d = '0;
      stall_d  = 1'b0;
    end else if (wb_valid && count_q != 2'd0) begin
      starve_d = (starve_q == CW'(STARVE_LIMIT)) ? starve_q : starve_q + CW'(1);
      stall_d  = stall_q || (starve_d == CW'(STARVE_LIMIT));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        fifo_q[i] <= '0;
      end
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      starve_q   <= '0;
      stall_q    <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        fifo_q[i] <= fifo_d[i];
      end
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      stall_q    <= stall_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign stall_req = stall_q;

  assign fwdA_hit  = rf_we_q && (rf_waddr_q == raddrA) && (raddrA != 5'd0);
  assign fwdB_hit  = rf_we_q && (rf_waddr_q == raddrB) && (raddrB != 5'd0);
  assign fwdA_data = rf_wdata_q;
  assign fwdB_data = rf_wdata_q;

  assign pendA = (raddrA != 5'd0) &&
                 ((fifo_q[0].live && fifo_q[0].addr == raddrA) ||
                  (fifo_q[1].live && fifo_q[1].addr == raddrA));
  assign pendB = (raddrB != 5'd0) &&
                 ((fifo_q[0].live && fifo_q[0].addr == raddrB) ||
                  (fifo_q[1].live && fifo_q[1].addr == raddrB));

endmodule

// File: tb/tb_regfile_writer.sv
// Directed bench for regfile_writer: each task drives one scenario and checks hand-computed values.
module tb_regfile_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_addr;
  logic [31:0] lu_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  raddrA, raddrB;
  logic        fwdA_hit, fwdB_hit;
  logic [31:0] fwdA_data, fwdB_data;
  logic        pendA, pendB;
  logic        stall_req;

  int checks = 0;
  int errors = 0;
  logic [31:0] rf_mem [32];

  regfile_writer #(.DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_addr(lu_addr), .lu_data(lu_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .raddrA(raddrA), .raddrB(raddrB),
    .fwdA_hit(fwdA_hit), .fwdB_hit(fwdB_hit),
    .fwdA_data(fwdA_data), .fwdB_data(fwdB_data),
    .pendA(pendA), .pendB(pendB),
    .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // Commits the current cycle's write into the bench regfile, then advances one edge.
  task automatic step();
    if (rf_we) rf_mem[rf_waddr] = rf_wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wb_valid = 0; wb_addr = 0; wb_data = 0;
    lu_valid = 0; lu_addr = 0; lu_data = 0; raddrA = 0; raddrB = 0;
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'h0;
    #3;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we got=%0b exp=0", rf_we); end
    checks++; if (rf_waddr !== 5'd0) begin errors++; $display("FAIL reset_rf_waddr got=%0d exp=0", rf_waddr); end
    checks++; if (rf_wdata !== 32'h0) begin errors++; $display("FAIL reset_rf_wdata got=%0h exp=0", rf_wdata); end
    checks++; if (lu_ready !== 1'b0) begin errors++; $display("FAIL reset_lu_ready got=%0b exp=0", lu_ready); end
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall got=%0b exp=0", stall_req); end
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL release_lu_ready got=%0b exp=1", lu_ready); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL release_rf_we got=%0b exp=0", rf_we); end
  endtask

  task automatic test_single_wb();
    wb_valid = 1; wb_addr = 5; wb_data = 32'hA5A5A5A5; raddrA = 5; raddrB = 6;
    step();
    wb_valid = 0;
    checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL wb_rf_we got=%0b exp=1", rf_we); end
    checks++; if (rf_waddr !== 5'd5) begin errors++; $display("FAIL wb_rf_waddr got=%0d exp=5", rf_waddr); end
    checks++; if (rf_wdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL wb_rf_wdata got=%0h exp=a5a5a5a5", rf_wdata); end
    checks++; if (fwdA_hit !== 1'b1) begin errors++; $display("FAIL wb_fwdA_hit got=%0b exp=1", fwdA_hit); end
    checks++; if (fwdA_data !== 32'hA5A5A5A5) begin errors++; $display("FAIL wb_fwdA_data got=%0h exp=a5a5a5a5", fwdA_data); end
    checks++; if (fwdB_hit !== 1'b0) begin errors++; $display("FAIL wb_fwdB_hit got=%0b exp=0", fwdB_hit); end
    raddrB = 5;
    #1;
    checks++; if (fwdB_hit !== 1'b1) begin errors++; $display("FAIL wb_fwdB_hit5 got=%0b exp=1", fwdB_hit); end
    step();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL wb_idle_rf_we got=%0b exp=0", rf_we); end
    checks++; if (fwdA_hit !== 1'b0) begin errors++; $display("FAIL wb_idle_fwdA got=%0b exp=0", fwdA_hit); end
    checks++; if (rf_mem[5] !== 32'hA5A5A5A5) begin errors++; $display("FAIL wb_commit_r5 got=%0h exp=a5a5a5a5", rf_mem[5]); end
  endtask

  task automatic test_zero_addr();
    wb_valid = 1; wb_addr = 0; wb_data = 32'h1; raddrA = 0;
    step();
    wb_valid = 0;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL zero_wb_rf_we got=%0b exp=0", rf_we); end
    checks++; if (fwdA_hit !== 1'b0) begin errors++; $display("FAIL zero_fwdA got=%0b exp=0", fwdA_hit); end
    lu_valid = 1; lu_addr = 0; lu_data = 32'h55;
    step();
    lu_valid = 0;
    checks++; if (pendA !== 1'b0) begin errors++; $display("FAIL zero_lu_pendA got=%0b exp=0", pendA); end
    checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL zero_lu_ready got=%0b exp=1", lu_ready); end
    step();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL zero_lu_rf_we got=%0b exp=0", rf_we); end
  endtask

  task automatic test_lu_path();
    raddrA = 9;
    lu_valid = 1; lu_addr = 9; lu_data = 32'h1234;
    step();
    lu_valid = 0;
    checks++; if (pendA !== 1'b1) begin errors++; $display("FAIL lu_pendA_n1 got=%0b exp=1", pendA); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL lu_rf_we_n1 got=%0b exp=0", rf_we); end
    step();
    checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL lu_rf_we_n2 got=%0b exp=1", rf_we); end
    checks++; if (rf_waddr !== 5'd9) begin errors++; $display("FAIL lu_rf_waddr got=%0d exp=9", rf_waddr); end
    checks++; if (rf_wdata !== 32'h1234) begin errors++; $display("FAIL lu_rf_wdata got=%0h exp=1234", rf_wdata); end
    checks++; if (pendA !== 1'b0) begin errors++; $display("FAIL lu_pendA_n2 got=%0b exp=0", pendA); end
    checks++; if (fwdA_hit !== 1'b1) begin errors++; $display("FAIL lu_fwdA got=%0b exp=1", fwdA_hit); end
    step();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL lu_rf_we_n3 got=%0b exp=0", rf_we); end
  endtask

  task automatic test_full_priority();
    wb_valid = 1; wb_addr = 3; wb_data = 32'h33;
    lu_valid = 1; lu_addr = 10; lu_data = 32'h1010;
    step();
    lu_addr = 11; lu_data = 32'h1111;
    checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL full_ready_c1 got=%0b exp=1", lu_ready); end
    step();
    checks++; if (lu_ready !== 1'b0) begin errors++; $display("FAIL full_ready_c2 got=%0b exp=0", lu_ready); end
    checks++; if (rf_waddr !== 5'd3 || rf_we !== 1'b1) begin errors++; $display("FAIL full_wb_prio got=%0b/%0d exp=1/3", rf_we, rf_waddr); end
    lu_addr = 12; lu_data = 32'h1212;
    step();
    checks++; if (lu_ready !== 1'b0) begin errors++; $display("FAIL full_ready_c3 got=%0b exp=0", lu_ready); end
    wb_valid = 0;
    step();
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd10 || rf_wdata !== 32'h1010) begin errors++; $display("FAIL full_drain0 got=%0b/%0d/%0h exp=1/10/1010", rf_we, rf_waddr, rf_wdata); end
    checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL full_ready_c4 got=%0b exp=1", lu_ready); end
    step();
    lu_valid = 0; raddrA = 12;
    #1;
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd11 || rf_wdata !== 32'h1111) begin errors++; $display("FAIL full_drain1 got=%0b/%0d/%0h exp=1/11/1111", rf_we, rf_waddr, rf_wdata); end
    checks++; if (pendA !== 1'b1) begin errors++; $display("FAIL full_pend12 got=%0b exp=1", pendA); end
    step();
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd12 || rf_wdata !== 32'h1212) begin errors++; $display("FAIL full_drain2 got=%0b/%0d/%0h exp=1/12/1212", rf_we, rf_waddr, rf_wdata); end
    step();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL full_empty got=%0b exp=0", rf_we); end
  endtask

  task automatic test_cancel();
    raddrA = 7;
    lu_valid = 1; lu_addr = 7; lu_data = 32'h77;
    step();
    lu_valid = 0;
    checks++; if (pendA !== 1'b1) begin errors++; $display("FAIL cancel_pend_before got=%0b exp=1", pendA); end
    wb_valid = 1; wb_addr = 7; wb_data = 32'hBEEF;
    step();
    wb_valid = 0;
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'hBEEF) begin errors++; $display("FAIL cancel_wb got=%0b/%0d/%0h exp=1/7/beef", rf_we, rf_waddr, rf_wdata); end
    checks++; if (pendA !== 1'b0) begin errors++; $display("FAIL cancel_pend_after got=%0b exp=0", pendA); end
    step();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL cancel_deq_we got=%0b exp=0", rf_we); end
    step();
    checks++; if (rf_mem[7] !== 32'hBEEF) begin errors++; $display("FAIL cancel_r7 got=%0h exp=beef", rf_mem[7]); end
    raddrA = 6;
    wb_valid = 1; wb_addr = 6; wb_data = 32'h66;
    lu_valid = 1; lu_addr = 6; lu_data = 32'h99;
    step();
    wb_valid = 0; lu_valid = 0;
    checks++; if (pendA !== 1'b0) begin errors++; $display("FAIL same_cycle_pend got=%0b exp=0", pendA); end
    step();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL same_cycle_deq_we got=%0b exp=0", rf_we); end
    step();
    checks++; if (rf_mem[6] !== 32'h66) begin errors++; $display("FAIL same_cycle_r6 got=%0h exp=66", rf_mem[6]); end
  endtask

  task automatic test_starve();
    lu_valid = 1; lu_addr = 20; lu_data = 32'h2020;
    wb_valid = 1; wb_addr = 21; wb_data = 32'h21;
    step();
    lu_valid = 0;
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL starve_c0 got=%0b exp=0", stall_req); end
    repeat (3) step();
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL starve_c3 got=%0b exp=0", stall_req); end
    step();
    checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL starve_c4 got=%0b exp=1", stall_req); end
    step();
    checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL starve_hold got=%0b exp=1", stall_req); end
    wb_valid = 0;
    step();
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL starve_clear got=%0b exp=0", stall_req); end
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd20) begin errors++; $display("FAIL starve_deq got=%0b/%0d exp=1/20", rf_we, rf_waddr); end
    step();
  endtask

  task automatic test_reset_mid();
    wb_valid = 1; wb_addr = 4; wb_data = 32'h44;
    lu_valid = 1; lu_addr = 13; lu_data = 32'h13;
    step();
    lu_addr = 14; lu_data = 32'h14;
    step();
    raddrA = 13;
    #1;
    checks++; if (lu_ready !== 1'b0 || pendA !== 1'b1) begin errors++; $display("FAIL mid_full got=%0b/%0b exp=0/1", lu_ready, pendA); end
    rst_n = 0;
    #1;
    checks++; if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'h0) begin errors++; $display("FAIL mid_rst_out got=%0b/%0d/%0h exp=0/0/0", rf_we, rf_waddr, rf_wdata); end
    checks++; if (lu_ready !== 1'b0 || pendA !== 1'b0 || stall_req !== 1'b0) begin errors++; $display("FAIL mid_rst_ctl got=%0b/%0b/%0b exp=0/0/0", lu_ready, pendA, stall_req); end
    wb_valid = 0; lu_valid = 0;
    @(posedge clk); @(negedge clk);
    rst_n = 1;
    step();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL mid_release_we got=%0b exp=0", rf_we); end
    checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL mid_release_ready got=%0b exp=1", lu_ready); end
    step();
    checks++; if (rf_we !== 1'b0 || pendA !== 1'b0) begin errors++; $display("FAIL mid_release_drained got=%0b/%0b exp=0/0", rf_we, pendA); end
  endtask

  initial begin
    test_reset();
    test_single_wb();
    test_zero_addr();
    test_lu_path();
    test_full_priority();
    test_cancel();
    test_starve();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_writer.md
REGFILE_WRITER -- requirements
Module: regfile_writer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the register data width.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, the number of blocked cycles before stall_req asserts.
REQ-003 SHALL have ports as follows; one clock; reset is asynchronous and active-low:
  clk  in  1  clock; all state updates on rising edge.
  rst_n  in  1  asynchronous active-low reset.
  wb_valid  in  1  pipeline writeback request; always accepted, no ready.
  wb_addr  in  5  pipeline destination register.
  wb_data  in  DATA_WIDTH  pipeline result.
  lu_valid  in  1  long-latency unit (mult/div/load-miss) write request.
  lu_ready  out  1  queue can accept an lu write.
  lu_addr  in  5  lu destination register.
  lu_data  in  DATA_WIDTH  lu result.
  rf_we  out  1  regfile write enable.
  rf_waddr  out  5  regfile write address.
  rf_wdata  out  DATA_WIDTH  regfile write data.
  raddrA, raddrB  in  5 each  decode-stage read addresses.
  fwdA_hit, fwdB_hit  out  1 each  read address matches the in-flight rf write.
  fwdA_data, fwdB_data  out  DATA_WIDTH each  bypass data.
  pendA, pendB  out  1 each  read address matches a live queued lu write.
  stall_req  out  1  request to freeze the pipeline so queued lu writes drain.

Function
REQ-004 SHALL hold lu writes in a 2-entry FIFO; each entry holds {live, addr, data}.
REQ-005 SHALL drive lu_ready = 1 iff FIFO count < 2 and rst_n high; a transfer occurs when lu_valid && lu_ready at a rising edge.
REQ-006 SHALL NOT allow lu writes to bypass the FIFO; the minimum lu latency is transfer at edge N, dequeue at edge N+1, rf_we high in cycle N+2.
REQ-007 SHALL register rf_we/rf_waddr/rf_wdata, so that a wb request sampled at edge N appears in cycle N+1 and the regfile commits at edge N+2.
REQ-008 SHALL give priority to wb_valid: when wb_valid is high, the output register loads the wb write and the FIFO does not dequeue.
REQ-009 SHALL dequeue the FIFO head when wb_valid is low and the FIFO is non-empty; rf_we is loaded with head.live.
REQ-010 SHALL suppress rf_we for address 0 from either source; lu writes to 0 are accepted and enqueued as not live.
REQ-011 SHALL clear live on every queued entry whose addr equals wb_addr when wb_valid is high, since the wb write is program-newer.
REQ-012 SHALL, on a same-cycle lu transfer whose lu_addr equals a valid wb_addr, enqueue that entry with live = 0.
REQ-013 SHALL allow enqueue and dequeue in the same cycle, leaving count unchanged; count never exceeds 2 or underflows.
REQ-014 SHALL drive fwdX_hit = rf_we && rf_waddr == raddrX && raddrX != 0, and fwdX_data = rf_wdata, combinationally.
REQ-015 SHALL drive pendX = 1 when any queued entry is live with addr == raddrX and raddrX != 0, combinationally.
REQ-016 SHALL count consecutive cycles with the FIFO non-empty and wb_valid high, and assert stall_req (registered) when the count reaches STARVE_LIMIT.
REQ-017 SHALL hold stall_req until a dequeue occurs, then clear stall_req and the counter at that edge.

Reset
REQ-018 SHALL, while rst_n is low, asynchronously clear the FIFO (count 0, all live 0), the starve counter, rf_we, rf_waddr, rf_wdata and stall_req to 0, and hold lu_ready at 0.
REQ-019 SHALL discard a reset asserted mid-operation together with all queued writes; no rf_we occurs in the first cycle after release.

Verification
REQ-020 Single wb: wb_valid, wb_addr=5, wb_data=0xA5A5A5A5 at edge 1 -> cycle 2 rf_we=1, rf_waddr=5, rf_wdata=0xA5A5A5A5; raddrA=5 gives fwdA_hit=1.
REQ-021 lu path: lu write to addr 9, data 0x1234, with wb idle -> rf_we to 9 in cycle N+2; pendA=1 with raddrA=9 in cycle N+1 only.
REQ-022 Full/priority: two lu transfers while wb_valid is high -> lu_ready=0; the third lu_valid is held; both writes drain in order once wb_valid is low.
REQ-023 Cancel: lu addr 7 queued, then wb_valid to addr 7 -> the wb write occurs; the lu entry dequeues with rf_we=0; the final r7 is the wb data.
REQ-024 Starvation: FIFO non-empty with wb_valid high for 4 cycles -> stall_req=1; drop wb_valid -> dequeue, then stall_req=0 the next cycle.
REQ-025 Reset mid-flight: 2 entries queued, rst_n pulsed low -> all outputs 0 immediately; after release, no rf_we and lu_ready=1.
